// File: rtl/dualport_ram_bw_if.sv
// Bus bundle for dualport_ram_bw: write port, read port, block select and status.
// The master side drives requests; the slave side is the RAM.
interface dualport_ram_bw_if #(
    parameter int MEM_WIDTH = 16,
    parameter int ADDR_SIZE = 10,
    parameter int BYTE_W    = 8
);
    logic [MEM_WIDTH-1:0]        din;
    logic [ADDR_SIZE-1:0]        addr_wr;
    logic [ADDR_SIZE-1:0]        addr_rd;
    logic                        wr_en;
    logic                        rd_en;
    logic [MEM_WIDTH/BYTE_W-1:0] be;
    logic                        blk_select;
    logic [MEM_WIDTH-1:0]        dout;
    logic                        rd_valid;
    logic                        busy;

    modport master (
        output din, addr_wr, addr_rd, wr_en, rd_en, be, blk_select,
        input  dout, rd_valid, busy
    );

    modport slave (
        input  din, addr_wr, addr_rd, wr_en, rd_en, be, blk_select,
        output dout, rd_valid, busy
    );
endinterface

// File: rtl/dualport_ram_bw.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write policy and an optional post-reset zero-fill sweep.
module dualport_ram_bw #(
    parameter int MEM_WIDTH      = 16,
    parameter int MEM_DEPTH      = 1024,
    parameter int ADDR_SIZE      = 10,
    parameter int BYTE_W         = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst,
    dualport_ram_bw_if.slave   bus
);
    localparam int NB = MEM_WIDTH / BYTE_W;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                   busy;
    logic                   wr_acc, rd_acc;
    logic                   wr_in_range, rd_in_range;
    logic [MEM_WIDTH-1:0]   old_word, rd_word;
    logic [MEM_WIDTH-1:0]   data_p0;
    logic                   vld_p0;

    function automatic logic [MEM_WIDTH-1:0] merge_lanes(
        input logic [MEM_WIDTH-1:0] base,
        input logic [MEM_WIDTH-1:0] upd,
        input logic [NB-1:0]        en
    );
        logic [MEM_WIDTH-1:0] res;
        res = base;
        for (int i = 0; i < NB; i++) begin
            if (en[i]) res[i*BYTE_W +: BYTE_W] = upd[i*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

    assign busy        = (state_q == CLEAR);
    assign bus.busy    = busy;
    assign wr_in_range = ({1'b0, bus.addr_wr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, bus.addr_rd} < DEPTH_EXT);
    assign wr_acc      = bus.wr_en && bus.blk_select && !busy && wr_in_range;
    assign rd_acc      = bus.rd_en && bus.blk_select && !busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = READY;
                cnt_d   = '0;
            end
        end
    end

    // The sweep owns the array while busy; user writes are only possible afterwards.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) mem[bus.addr_wr][i*BYTE_W +: BYTE_W] <= bus.din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        old_word = rd_in_range ? mem[bus.addr_rd] : '0;
        rd_word  = old_word;
        if (RDW_MODE == 1 && wr_acc && bus.addr_wr == bus.addr_rd) begin
            rd_word = merge_lanes(old_word, bus.din, bus.be);
        end
    end

    // Stage p0: array read captured on the accepting edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) data_p0 <= rd_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [MEM_WIDTH-1:0] data_p1;
            logic                 vld_p1;

            // Stage p1: extra output register for timing
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) data_p1 <= data_p0;
                end
            end

            assign bus.dout     = data_p1;
            assign bus.rd_valid = vld_p1;
        end else begin : g_lat1
            assign bus.dout     = data_p0;
            assign bus.rd_valid = vld_p0;
        end
    endgenerate
endmodule

// File: tb/tb_dualport_ram_bw.sv
// Bench for dualport_ram_bw: five instances (latency x read-during-write mode, plus a
// shallow one for out-of-range addresses) driven in lockstep and checked against a model.
module tb_dualport_ram_bw;
    localparam int NI = 5;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [9:0]  addr_wr, addr_rd;
    logic        wr_en, rd_en, blk;
    logic [1:0]  be;

    logic [15:0] dout_w [NI];
    logic        vld_w  [NI];
    logic        busy_w [NI];

    int n_chk = 0;
    int n_err = 0;

    function automatic int dep(int k);
        return (k == 4) ? 768 : 1024;
    endfunction
    function automatic int lat(int k);
        return (k == 2 || k == 3) ? 2 : 1;
    endfunction
    function automatic int mode(int k);
        return (k == 1 || k == 3) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dualport_ram_bw_if #(.MEM_WIDTH(16), .ADDR_SIZE(10), .BYTE_W(8)) bus ();
        assign bus.din        = din;
        assign bus.addr_wr    = addr_wr;
        assign bus.addr_rd    = addr_rd;
        assign bus.wr_en      = wr_en;
        assign bus.rd_en      = rd_en;
        assign bus.be         = be;
        assign bus.blk_select = blk;
        assign dout_w[g]      = bus.dout;
        assign vld_w[g]       = bus.rd_valid;
        assign busy_w[g]      = bus.busy;

        dualport_ram_bw #(
            .MEM_WIDTH(16),
            .MEM_DEPTH((g == 4) ? 768 : 1024),
            .ADDR_SIZE(10),
            .BYTE_W(8),
            .RD_LATENCY((g == 2 || g == 3) ? 2 : 1),
            .RDW_MODE((g == 1 || g == 3) ? 1 : 0),
            .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array per instance, sweep as a count of cycles left,
    // latency as a one-entry delay line.
    logic [15:0] mm   [NI][1024];
    int          left [NI];
    logic        s_v  [NI];
    logic [15:0] s_d  [NI];
    logic        e_v  [NI];
    logic [15:0] e_d  [NI];

    initial begin
        logic        bsy, rd, wr, nv;
        logic [15:0] rv, nd;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int k = 0; k < NI; k++) begin
                    left[k] = dep(k);
                    s_v[k] = 1'b0; s_d[k] = '0;
                    e_v[k] = 1'b0; e_d[k] = '0;
                end
            end else begin
                for (int k = 0; k < NI; k++) begin
                    bsy = (left[k] > 0);
                    rd  = rd_en && blk && !bsy;
                    wr  = wr_en && blk && !bsy && (int'(addr_wr) < dep(k));
                    rv  = (int'(addr_rd) < dep(k)) ? mm[k][addr_rd] : 16'h0000;
                    if (rd && wr && addr_rd == addr_wr && mode(k) == 1) begin
                        for (int b = 0; b < 2; b++) if (be[b]) rv[b*8 +: 8] = din[b*8 +: 8];
                    end
                    if (wr) begin
                        for (int b = 0; b < 2; b++) if (be[b]) mm[k][addr_wr][b*8 +: 8] = din[b*8 +: 8];
                    end
                    if (bsy) begin
                        mm[k][dep(k) - left[k]] = 16'h0000;
                        left[k] = left[k] - 1;
                    end
                    if (lat(k) == 1) begin
                        nv = rd; nd = rv;
                    end else begin
                        nv = s_v[k]; nd = s_d[k];
                        s_v[k] = rd; s_d[k] = rv;
                    end
                    e_v[k] = nv;
                    if (nv) e_d[k] = nd;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                for (int k = 0; k < NI; k++) begin
                    n_chk += 3;
                    if (busy_w[k] !== (left[k] > 0)) begin
                        n_err++;
                        $display("FAIL cmp_busy[%0d]: got %b expected %b", k, busy_w[k], left[k] > 0);
                    end
                    if (vld_w[k] !== e_v[k]) begin
                        n_err++;
                        $display("FAIL cmp_valid[%0d]: got %b expected %b", k, vld_w[k], e_v[k]);
                    end
                    if (dout_w[k] !== e_d[k]) begin
                        n_err++;
                        $display("FAIL cmp_dout[%0d]: got %h expected %h", k, dout_w[k], e_d[k]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic we, input logic [9:0] wa, input logic [15:0] d,
                        input logic [1:0] b, input logic re, input logic [9:0] ra,
                        input logic bs);
        wr_en = we; addr_wr = wa; din = d; be = b;
        rd_en = re; addr_rd = ra; blk = bs;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b0, 10'd0, 1'b1);
    endtask

    // Releases reset with requests aimed at addr 9 held during the sweep, and times busy.
    task automatic release_and_sweep(input string name);
        int n;
        wr_en = 1'b1; addr_wr = 10'd9; din = 16'hFFFF; be = 2'b11;
        rd_en = 1'b1; addr_rd = 10'd9; blk = 1'b1;
        rst = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy_w[0]) break;
        end
        chk(name, n, 1024);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; blk = 1'b0;
        din = '0; addr_wr = '0; addr_rd = '0; be = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_dout[%0d]", k), dout_w[k], 16'h0000);
            chk($sformatf("reset_valid[%0d]", k), vld_w[k], 1'b0);
            chk($sformatf("reset_busy[%0d]", k), busy_w[k], 1'b1);
        end

        release_and_sweep("sweep_len_first");
        idle();

        // Block-select gating, then confirm the busy-period writes to addr 9 were dropped
        step(1'b1, 10'd9, 16'hFFFF, 2'b11, 1'b1, 10'd9, 1'b0);
        chk("gated_read_valid", vld_w[0], 1'b0);
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd9, 1'b1);
        chk("mem9_unchanged", dout_w[0], 16'h0000);
        chk("mem9_valid", vld_w[0], 1'b1);

        // Byte enables
        step(1'b1, 10'd3, 16'hABCD, 2'b11, 1'b0, 10'd0, 1'b1);
        step(1'b1, 10'd3, 16'h1234, 2'b01, 1'b0, 10'd0, 1'b1);
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd3, 1'b1);
        chk("be_merge_l1", dout_w[0], 16'hAB34);
        idle();
        chk("be_merge_l2", dout_w[2], 16'hAB34);
        chk("hold_valid_l1", vld_w[0], 1'b0);
        chk("hold_dout_l1", dout_w[0], 16'hAB34);

        // Two-cycle latency, back-to-back reads
        step(1'b1, 10'd1, 16'h0011, 2'b11, 1'b0, 10'd0, 1'b1);
        step(1'b1, 10'd2, 16'h0022, 2'b11, 1'b0, 10'd0, 1'b1);
        step(1'b1, 10'd3, 16'h0033, 2'b11, 1'b0, 10'd0, 1'b1);
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd1, 1'b1);
        chk("lat2_first_edge_valid", vld_w[2], 1'b0);
        chk("lat1_first", dout_w[0], 16'h0011);
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd2, 1'b1);
        chk("lat2_r1_valid", vld_w[2], 1'b1);
        chk("lat2_r1", dout_w[2], 16'h0011);
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd3, 1'b1);
        chk("lat2_r2", dout_w[2], 16'h0022);
        idle();
        chk("lat2_r3", dout_w[2], 16'h0033);
        chk("lat2_r3_valid", vld_w[2], 1'b1);
        idle();
        chk("lat2_done_valid", vld_w[2], 1'b0);

        // Read during write to the same address
        step(1'b1, 10'd7, 16'h5555, 2'b11, 1'b0, 10'd0, 1'b1);
        step(1'b1, 10'd7, 16'hAAAA, 2'b10, 1'b1, 10'd7, 1'b1);
        chk("rdw_old", dout_w[0], 16'h5555);
        chk("rdw_new", dout_w[1], 16'hAA55);
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd7, 1'b1);
        chk("rdw_follow_m0", dout_w[0], 16'hAA55);
        chk("rdw_follow_m1", dout_w[1], 16'hAA55);
        chk("rdw_l2_m1", dout_w[3], 16'hAA55);

        // Out-of-range read on the shallow instance
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd1000, 1'b1);
        chk("oor_dout", dout_w[4], 16'h0000);
        chk("oor_valid", vld_w[4], 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [9:0] wa, ra;
            wa = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ra, ($urandom_range(0, 7) != 0));
        end

        // Mid-run asynchronous reset with data on the output
        step(1'b1, 10'd20, 16'hBEEF, 2'b11, 1'b0, 10'd0, 1'b1);
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd20, 1'b1);
        chk("pre_reset_dout", dout_w[0], 16'hBEEF);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_dout", dout_w[0], 16'h0000);
        chk("async_reset_valid", vld_w[0], 1'b0);
        chk("async_reset_busy", busy_w[0], 1'b1);
        @(negedge clk);
        release_and_sweep("sweep_len_second");

        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd5, 1'b1);
        chk("clear_addr5", dout_w[0], 16'h0000);
        chk("clear_addr5_valid", vld_w[0], 1'b1);
        step(1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, 10'd1023, 1'b1);
        chk("clear_addr1023", dout_w[0], 16'h0000);
        chk("clear_addr1023_valid", vld_w[0], 1'b1);
        repeat (3) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dualport_ram_bw.md
Name: dualport_ram_bw

Overview:
- Parametrised next-generation simple dual-port RAM: one write port and one read port, sharing one clock.
- Adds per-byte write enables and a selectable read latency of 1 or 2 cycles.
- Adds a defined read-during-write policy and a read-valid strobe.
- Adds an optional post-reset memory-clear sweep with a busy flag.
- Used as a buffer/scratch memory behind block-select decode in the datapath.

Parameters:
- MEM_WIDTH, 16, data word width; must be a multiple of BYTE_W.
- MEM_DEPTH, 1024, number of words; MEM_DEPTH <= 2**ADDR_SIZE.
- ADDR_SIZE, 10, address width of both ports.
- BYTE_W, 8, bits per byte-enable lane.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write policy: 0 returns old data, 1 returns new (forwarded) data.
- CLEAR_ON_RESET, 1, when 1 a zero-fill sweep runs after reset release.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  MEM_WIDTH  write data.
- addr_wr  in  ADDR_SIZE  write address.
- addr_rd  in  ADDR_SIZE  read address.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- be  in  MEM_WIDTH/BYTE_W  byte write enables; bit i covers din[i*BYTE_W +: BYTE_W].
- blk_select  in  1  block select; gates both ports.
- dout  out  MEM_WIDTH  read data.
- rd_valid  out  1  one-cycle strobe: dout holds data for an accepted read.
- busy  out  1  high while the clear sweep runs; all requests are ignored.

Behaviour:
- Reset (rst=0, asynchronous):
  - dout=0 and rd_valid=0.
  - Read pipeline stages and their valid bits clear.
  - Clear counter resets to 0.
  - busy=CLEAR_ON_RESET.
  - Array contents are not reset asynchronously.
- Clear FSM has two states, CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - In CLEAR, each clk edge writes 0 to mem[cnt] and increments cnt.
  - After writing mem[MEM_DEPTH-1], the FSM moves to READY and busy drops on that same edge. Busy time is exactly MEM_DEPTH cycles.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- Write acceptance: wr_en && blk_select && !busy && addr_wr < MEM_DEPTH.
  - On that edge, mem[addr_wr] lane i takes din lane i for each be[i]=1; other lanes are unchanged.
  - be=0 gives a no-op write.
- Read acceptance: rd_en && blk_select && !busy.
  - RD_LATENCY=1: dout updates and rd_valid=1 on the first edge after acceptance.
  - RD_LATENCY=2: the same update happens one edge later via an extra register stage.
  - Back-to-back reads give one result per cycle; there are no bubbles.
  - addr_rd >= MEM_DEPTH returns 0 and still asserts rd_valid.
- When no read completes, rd_valid=0 and dout holds its last value.
- Same-address read and write accepted on the same edge:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns new lanes where be[i]=1 and old lanes elsewhere.
- Different addresses on the same edge: the ports are fully independent.
- blk_select=0 or busy=1: the request is dropped. It is not queued, and no rd_valid is issued for it.
- Reads already in the pipeline when busy or blk_select changes still complete.

Test Plan:
- Reset/clear (RD_LATENCY=1, CLEAR_ON_RESET=1): assert rst=0 mid-run -> dout=0, rd_valid=0, busy=1 immediately. Release rst -> busy stays high exactly 1024 cycles. Then read addr 5 and 1023 -> dout=0x0000 with rd_valid=1, one cycle after each request.
- Byte enables: write 0xABCD be=2'b11 to addr 3, then write 0x1234 be=2'b01 to addr 3. Read addr 3 -> 0xAB34.
- Latency: RD_LATENCY=2, reads of addrs 1,2,3 on consecutive cycles after writing 0x0011/0x0022/0x0033 -> rd_valid high for 3 cycles starting 2 edges after the first request; dout sequence 0x0011, 0x0022, 0x0033.
- Read-during-write: mem[7]=0x5555; same edge write 0xAAAA be=2'b10 to 7 and read 7 -> RDW_MODE=0 gives 0x5555, RDW_MODE=1 gives 0xAA55. A follow-up read gives 0xAA55 in both modes.
- Gating: blk_select=0 with wr_en=1, din=0xFFFF, addr 9 -> mem[9] unchanged, rd_valid stays 0 for a concurrent read. Write and read requests issued during busy -> ignored; mem stays 0 after the sweep.
- Random: 200 cycles of random addresses, data, be, enables and blk_select against a reference model -> every rd_valid cycle matches the expected dout.
